// File: rtl/delivery_ctrl_if.sv
// delivery_ctrl_if: sensor inputs and actuator/display outputs of the delivery controller.
interface delivery_ctrl_if #(
    parameter int COLOR_W = 2,
    parameter int CNT_W   = 8
);
    logic               hall;
    logic [COLOR_W-1:0] object_color;
    logic [COLOR_W-1:0] station_color;
    logic               end_of_track;
    logic               uturn_finished;
    logic               buzz_finished;
    logic               return_en;
    logic               en_tracking;
    logic               en_uturn;
    logic               en_buzz;
    logic [3:0]         state_code;
    logic [COLOR_W-1:0] color_latched;
    logic [CNT_W-1:0]   deliveries;
    logic               fault;

    modport master (
        output hall, object_color, station_color, end_of_track, uturn_finished, buzz_finished, return_en,
        input  en_tracking, en_uturn, en_buzz, state_code, color_latched, deliveries, fault
    );

    modport slave (
        input  hall, object_color, station_color, end_of_track, uturn_finished, buzz_finished, return_en,
        output en_tracking, en_uturn, en_buzz, state_code, color_latched, deliveries, fault
    );
endinterface

// File: rtl/delivery_ctrl.sv
// delivery_ctrl: cart sequencer (load, send, debounced station match, u-turn, return) with per-leg watchdog.
module delivery_ctrl #(
    parameter int COLOR_W     = 2,
    parameter int MATCH_HOLD  = 4,
    parameter int TIMEOUT_CYC = 500000000,
    parameter int TMR_W       = 29,
    parameter int CNT_W       = 8
) (
    input logic            clk,
    input logic            rst,
    delivery_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SEND    = 4'd1,
        S_MATCH   = 4'd2,
        S_EOT     = 4'd3,
        S_UTURN   = 4'd4,
        S_RETURN  = 4'd5,
        S_NOCOLOR = 4'd6,
        S_FAULT   = 4'd7
    } state_t;

    localparam int MW = $clog2(MATCH_HOLD + 1);

    state_t             state_q, state_d;
    logic               hall_q, returning_q;
    logic [MW-1:0]      match_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [COLOR_W-1:0] color_q;
    logic [CNT_W-1:0]   dlv_q;
    logic               en_trk_q, en_ut_q, en_bz_q, fault_q;
    logic               hall_rise, matching, match_done, timed, expired;

    assign hall_rise  = bus.hall & ~hall_q;
    assign matching   = bus.station_color == color_q;
    assign match_done = matching && match_q == MW'(MATCH_HOLD - 1);
    assign timed      = state_q inside {S_SEND, S_UTURN, S_RETURN};
    assign expired    = timed && tmr_q == TMR_W'(TIMEOUT_CYC - 1);

    // Exits are tested before expiry so a leg finishing on its last cycle never faults.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = hall_rise ? (bus.object_color == '0 ? S_NOCOLOR : S_SEND) : S_IDLE;
            S_NOCOLOR: state_d = bus.buzz_finished ? S_IDLE : S_NOCOLOR;
            S_SEND:    state_d = match_done ? S_MATCH : bus.end_of_track ? S_EOT : expired ? S_FAULT : S_SEND;
            S_MATCH:   state_d = hall_rise ? (bus.return_en ? S_UTURN : S_IDLE) : S_MATCH;
            S_EOT:     state_d = bus.buzz_finished ? S_UTURN : S_EOT;
            S_UTURN:   state_d = bus.uturn_finished ? (returning_q ? S_IDLE : S_RETURN) : expired ? S_FAULT : S_UTURN;
            S_RETURN:  state_d = bus.end_of_track ? S_UTURN : expired ? S_FAULT : S_RETURN;
            S_FAULT:   state_d = hall_rise ? S_IDLE : S_FAULT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            hall_q      <= 1'b0;
            returning_q <= 1'b0;
            match_q     <= '0;
            tmr_q       <= '0;
            color_q     <= '0;
            dlv_q       <= '0;
            en_trk_q    <= 1'b0;
            en_ut_q     <= 1'b0;
            en_bz_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hall_q      <= bus.hall;
            match_q     <= (state_q == S_SEND && state_d == S_SEND && matching) ? match_q + 1'b1 : '0;
            tmr_q       <= (state_d != state_q || !timed) ? '0 : tmr_q + 1'b1;
            color_q     <= (state_q == S_IDLE && state_d == S_SEND) ? bus.object_color :
                           (state_d inside {S_IDLE, S_RETURN}) ? '0 : color_q;
            returning_q <= state_d == S_RETURN ? 1'b1 : (state_d == S_IDLE || state_q == S_EOT) ? 1'b0 : returning_q;
            dlv_q       <= (state_d == S_MATCH && state_q != S_MATCH && ~&dlv_q) ? dlv_q + 1'b1 : dlv_q;
            en_trk_q    <= state_d inside {S_SEND, S_RETURN};
            en_ut_q     <= state_d == S_UTURN;
            en_bz_q     <= state_d inside {S_NOCOLOR, S_MATCH, S_EOT, S_FAULT};
            fault_q     <= state_d == S_FAULT;
        end
    end

    assign bus.en_tracking   = en_trk_q;
    assign bus.en_uturn      = en_ut_q;
    assign bus.en_buzz       = en_bz_q;
    assign bus.state_code    = state_q;
    assign bus.color_latched = color_q;
    assign bus.deliveries    = dlv_q;
    assign bus.fault         = fault_q;
endmodule

// File: tb/tb_delivery_ctrl.sv
// tb_delivery_ctrl: directed scenarios plus randomized run against a behavioural cart model.
module tb_delivery_ctrl;
    localparam int CW = 2;
    localparam int MH = 4;
    localparam int TO = 16;
    localparam int TW = 5;
    localparam int NW = 2;

    localparam logic [7:0] O_IDLE    = 8'h00;
    localparam logic [7:0] O_SEND    = 8'h18;
    localparam logic [7:0] O_MATCH   = 8'h22;
    localparam logic [7:0] O_EOT     = 8'h32;
    localparam logic [7:0] O_UTURN   = 8'h44;
    localparam logic [7:0] O_RETURN  = 8'h58;
    localparam logic [7:0] O_NOCOLOR = 8'h62;
    localparam logic [7:0] O_FAULT   = 8'h73;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    delivery_ctrl_if #(.COLOR_W(CW), .CNT_W(NW)) bus();
    delivery_ctrl #(.COLOR_W(CW), .MATCH_HOLD(MH), .TIMEOUT_CYC(TO), .TMR_W(TW), .CNT_W(NW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: state as display code, run = consecutive matching SEND cycles, leg = cycles spent in a timed leg.
    int m_st, m_run, m_leg, m_ret, m_dlv;
    logic m_hp;
    logic [CW-1:0] m_col;

    task automatic model_reset();
        m_st = 0; m_run = 0; m_leg = 0; m_ret = 0; m_dlv = 0; m_hp = 1'b0; m_col = '0;
    endtask

    task automatic model_step();
        logic rise;
        int nxt, run;
        rise = bus.hall && !m_hp;
        nxt = m_st;
        run = 0;
        case (m_st)
            0: if (rise) nxt = (bus.object_color == '0) ? 6 : 1;
            1: begin
                run = (bus.station_color == m_col) ? m_run + 1 : 0;
                if (run >= MH) nxt = 2;
                else if (bus.end_of_track) nxt = 3;
                else if (m_leg + 1 >= TO) nxt = 7;
            end
            2: if (rise) nxt = bus.return_en ? 4 : 0;
            3: if (bus.buzz_finished) nxt = 4;
            4: if (bus.uturn_finished) nxt = m_ret ? 0 : 5; else if (m_leg + 1 >= TO) nxt = 7;
            5: if (bus.end_of_track) nxt = 4; else if (m_leg + 1 >= TO) nxt = 7;
            6: if (bus.buzz_finished) nxt = 0;
            7: if (rise) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 2 && m_st != 2 && m_dlv < (1 << NW) - 1) m_dlv++;
        if (m_st == 0 && nxt == 1) m_col = bus.object_color;
        if (nxt == 0 || nxt == 5) m_col = '0;
        if (nxt == 5) m_ret = 1;
        if (nxt == 0) m_ret = 0;
        m_leg = (nxt == m_st && (m_st == 1 || m_st == 4 || m_st == 5)) ? m_leg + 1 : 0;
        m_run = (nxt == 1) ? run : 0;
        m_hp = bus.hall;
        m_st = nxt;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_step(); else model_reset();
            #1;
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.state_code, bus.en_tracking, bus.en_uturn, bus.en_buzz, bus.fault};
    endfunction

    task automatic hall_pulse(input logic [CW-1:0] oc);
        bus.object_color = oc;
        bus.hall = 1'b1;
        tick();
        bus.hall = 1'b0;
    endtask

    task automatic test_reset();
        bus.hall = 0; bus.object_color = '0; bus.station_color = '0; bus.end_of_track = 0;
        bus.uturn_finished = 0; bus.buzz_finished = 0; bus.return_en = 1;
        model_reset();
        tick(2);
        if (outs() !== O_IDLE) begin failures++; $display("FAIL reset_outs: got %h exp %h", outs(), O_IDLE); end
        checks++;
        if ({bus.color_latched, bus.deliveries} !== '0) begin failures++; $display("FAIL reset_regs: got %h exp 0", {bus.color_latched, bus.deliveries}); end
        checks++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_delivery();
        hall_pulse(2'd2);
        if (outs() !== O_SEND || bus.color_latched !== 2'd2) begin failures++; $display("FAIL basic_send: got %h/%0d exp %h/2", outs(), bus.color_latched, O_SEND); end
        checks++;
        bus.station_color = 2'd2;
        tick(3);
        if (outs() !== O_SEND) begin failures++; $display("FAIL basic_hold3: got %h exp %h", outs(), O_SEND); end
        checks++;
        tick();
        if (outs() !== O_MATCH || bus.deliveries !== 2'd1) begin failures++; $display("FAIL basic_match: got %h/%0d exp %h/1", outs(), bus.deliveries, O_MATCH); end
        checks++;
        bus.station_color = '0;
        bus.return_en = 1;
        tick();
        hall_pulse(2'd1);
        if (outs() !== O_UTURN) begin failures++; $display("FAIL basic_uturn: got %h exp %h", outs(), O_UTURN); end
        checks++;
        bus.uturn_finished = 1; tick(); bus.uturn_finished = 0;
        if (outs() !== O_RETURN || bus.color_latched !== '0) begin failures++; $display("FAIL basic_return: got %h/%0d exp %h/0", outs(), bus.color_latched, O_RETURN); end
        checks++;
        bus.end_of_track = 1; tick(); bus.end_of_track = 0;
        if (outs() !== O_UTURN) begin failures++; $display("FAIL basic_uturn2: got %h exp %h", outs(), O_UTURN); end
        checks++;
        bus.uturn_finished = 1; tick(); bus.uturn_finished = 0;
        if (outs() !== O_IDLE || bus.color_latched !== '0) begin failures++; $display("FAIL basic_idle: got %h/%0d exp %h/0", outs(), bus.color_latched, O_IDLE); end
        checks++;
    endtask

    task automatic test_debounce();
        hall_pulse(2'd1);
        bus.station_color = 2'd1; tick(3);
        bus.station_color = 2'd3; tick();
        if (outs() !== O_SEND) begin failures++; $display("FAIL debounce_break: got %h exp %h", outs(), O_SEND); end
        checks++;
        bus.station_color = 2'd1; tick(3);
        if (outs() !== O_SEND) begin failures++; $display("FAIL debounce_3: got %h exp %h", outs(), O_SEND); end
        checks++;
        tick();
        if (outs() !== O_MATCH || bus.deliveries !== 2'd2) begin failures++; $display("FAIL debounce_match: got %h/%0d exp %h/2", outs(), bus.deliveries, O_MATCH); end
        checks++;
        bus.station_color = '0;
        bus.return_en = 0;
        hall_pulse(2'd2);
        if (outs() !== O_IDLE || bus.color_latched !== '0) begin failures++; $display("FAIL noreturn_idle: got %h/%0d exp %h/0", outs(), bus.color_latched, O_IDLE); end
        checks++;
        bus.return_en = 1;
        tick();
    endtask

    task automatic test_priority_eot();
        hall_pulse(2'd3);
        bus.station_color = 2'd3; tick(3);
        bus.end_of_track = 1; tick(); bus.end_of_track = 0;
        if (outs() !== O_MATCH || bus.deliveries !== 2'd3) begin failures++; $display("FAIL prio_match: got %h/%0d exp %h/3", outs(), bus.deliveries, O_MATCH); end
        checks++;
        bus.station_color = '0;
        hall_pulse(2'd1);
        bus.uturn_finished = 1; tick(); bus.uturn_finished = 0;
        bus.end_of_track = 1; tick(); bus.end_of_track = 0;
        bus.uturn_finished = 1; tick(); bus.uturn_finished = 0;
        if (outs() !== O_IDLE) begin failures++; $display("FAIL prio_idle: got %h exp %h", outs(), O_IDLE); end
        checks++;
        hall_pulse(2'd1);
        bus.end_of_track = 1; tick(); bus.end_of_track = 0;
        if (outs() !== O_EOT) begin failures++; $display("FAIL eot_enter: got %h exp %h", outs(), O_EOT); end
        checks++;
        bus.buzz_finished = 1; tick(); bus.buzz_finished = 0;
        if (outs() !== O_UTURN) begin failures++; $display("FAIL eot_uturn: got %h exp %h", outs(), O_UTURN); end
        checks++;
        bus.uturn_finished = 1; tick(); bus.uturn_finished = 0;
        if (outs() !== O_RETURN) begin failures++; $display("FAIL eot_return: got %h exp %h", outs(), O_RETURN); end
        checks++;
        bus.end_of_track = 1; tick(); bus.end_of_track = 0;
        bus.uturn_finished = 1; tick(); bus.uturn_finished = 0;
    endtask

    task automatic test_watchdog();
        bus.object_color = 2'd2;
        bus.hall = 1'b1;
        tick();
        tick(TO - 1);
        if (outs() !== O_SEND) begin failures++; $display("FAIL wd_before: got %h exp %h", outs(), O_SEND); end
        checks++;
        tick();
        if (outs() !== O_FAULT) begin failures++; $display("FAIL wd_fault: got %h exp %h", outs(), O_FAULT); end
        checks++;
        tick(3);
        if (outs() !== O_FAULT) begin failures++; $display("FAIL wd_hall_level: got %h exp %h", outs(), O_FAULT); end
        checks++;
        bus.hall = 1'b0; tick();
        bus.hall = 1'b1; tick(); bus.hall = 1'b0;
        if (outs() !== O_IDLE || bus.color_latched !== '0 || bus.deliveries !== 2'd3) begin failures++; $display("FAIL wd_exit: got %h/%0d/%0d exp %h/0/3", outs(), bus.color_latched, bus.deliveries, O_IDLE); end
        checks++;
        tick();
    endtask

    task automatic test_modes();
        hall_pulse(2'd2);
        bus.station_color = 2'd2; tick(4);
        if (outs() !== O_MATCH || bus.deliveries !== 2'd3) begin failures++; $display("FAIL saturate: got %h/%0d exp %h/3", outs(), bus.deliveries, O_MATCH); end
        checks++;
        bus.station_color = '0;
        bus.return_en = 0;
        hall_pulse(2'd1);
        bus.return_en = 1;
        tick();
        hall_pulse(2'd0);
        if (outs() !== O_NOCOLOR) begin failures++; $display("FAIL nocolor_enter: got %h exp %h", outs(), O_NOCOLOR); end
        checks++;
        tick(3);
        if (outs() !== O_NOCOLOR) begin failures++; $display("FAIL nocolor_hold: got %h exp %h", outs(), O_NOCOLOR); end
        checks++;
        bus.buzz_finished = 1; tick(); bus.buzz_finished = 0;
        if (outs() !== O_IDLE) begin failures++; $display("FAIL nocolor_exit: got %h exp %h", outs(), O_IDLE); end
        checks++;
    endtask

    task automatic test_reset_mid_return();
        hall_pulse(2'd1);
        bus.end_of_track = 1; tick(); bus.end_of_track = 0;
        bus.buzz_finished = 1; tick(); bus.buzz_finished = 0;
        bus.uturn_finished = 1; tick(); bus.uturn_finished = 0;
        if (outs() !== O_RETURN) begin failures++; $display("FAIL rst_setup: got %h exp %h", outs(), O_RETURN); end
        checks++;
        rst = 1'b0;
        #1;
        if (outs() !== O_IDLE || {bus.color_latched, bus.deliveries} !== '0) begin failures++; $display("FAIL rst_async: got %h/%h exp 00/0", outs(), {bus.color_latched, bus.deliveries}); end
        checks++;
        model_reset();
        tick();
        rst = 1'b1;
        tick();
        if (outs() !== O_IDLE) begin failures++; $display("FAIL rst_after: got %h exp %h", outs(), O_IDLE); end
        checks++;
    endtask

    task automatic test_random();
        logic [11:0] obs, exp;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.hall = ~bus.hall;
            bus.object_color = CW'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.station_color = ($urandom_range(0, 1) == 1) ? m_col : CW'($urandom_range(0, 3));
            bus.end_of_track = $urandom_range(0, 9) == 0;
            bus.uturn_finished = $urandom_range(0, 5) == 0;
            bus.buzz_finished = $urandom_range(0, 4) == 0;
            bus.return_en = $urandom_range(0, 1) == 1;
            tick();
            exp = {4'(m_st), m_st == 1 || m_st == 5, m_st == 4, m_st inside {2, 3, 6, 7}, m_st == 7, m_col, NW'(m_dlv)};
            obs = {outs(), bus.color_latched, bus.deliveries};
            if (obs !== exp) begin failures++; $display("FAIL random_cycle%0d: got %h exp %h", i, obs, exp); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_delivery();
        test_debounce();
        test_priority_eot();
        test_watchdog();
        test_modes();
        test_reset_mid_return();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
